hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It tracks in-flight register writes through EX, MEM and WB, and consumes the per-operand read-timing codes produced at ID. It emits a load-use stall for IF/ID and forward-source selects for the EX and MEM operand muxes. It is the write-side counterpart of the ID read-timing decode.

---
 rtl/hazard_unit_pkg.sv | 71 +++++++
 rtl/instr_reg_write.sv | 50 +++++
 rtl/hazard_unit.sv | 95 +++++++++
 tb/tb_hazard_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: instruction fields, opcodes,
// read-timing and forward-select codes, and per-stage tracking records.
package hazard_unit_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnJr    = 6'h08;

    localparam logic [1:0] ReadNone = 2'b00;
    localparam logic [1:0] ReadEx   = 2'b01;
    localparam logic [1:0] ReadMem  = 2'b10;

    localparam logic [1:0] FwdReg   = 2'b00;
    localparam logic [1:0] FwdExMem = 2'b01;
    localparam logic [1:0] FwdMemWb = 2'b10;

    typedef struct packed {
        logic       v;
        logic [4:0] dest;
        logic [1:0] ready;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] read_rs;
        logic [1:0] read_rt;
    } ex_stage_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dest;
        logic [1:0] ready;
        logic [4:0] rt;
        logic [1:0] read_rt;
    } mem_stage_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dest;
    } wb_stage_t;

    function automatic logic [5:0] op_f(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] fn_f(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic [4:0] rs_f(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] rt_f(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] rd_f(input logic [31:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/instr_reg_write.sv
// Combinational write decode: which register an instruction writes and
// the stage at whose end the result becomes available.
module instr_reg_write
    import hazard_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic        wen,
    output logic [4:0]  dest,
    output logic [1:0]  ready
);

    logic wen_raw;
    logic unused_shamt;

    assign unused_shamt = ^instr[10:6];

    always_comb begin
        wen_raw = 1'b0;
        dest    = 5'd0;
        ready   = ReadNone;
        case (op_f(instr))
            OpRtype: begin
                if (fn_f(instr) != FnJr) begin
                    wen_raw = 1'b1;
                    dest    = rd_f(instr);
                    ready   = ReadEx;
                end
            end
            OpLw: begin
                wen_raw = 1'b1;
                dest    = rt_f(instr);
                ready   = ReadMem;
            end
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
                wen_raw = 1'b1;
                dest    = rt_f(instr);
                ready   = ReadEx;
            end
            OpJal: begin
                wen_raw = 1'b1;
                dest    = 5'd31;
                ready   = ReadEx;
            end
            default: ;
        endcase
        // $0 is never a real destination, so it can never be matched downstream.
        wen = wen_raw & (dest != 5'd0);
    end

endmodule

// File: rtl/hazard_unit.sv
// Tracks in-flight register writes through EX/MEM/WB and derives the
// load-use stall, the operand forward selects and a saturating stall counter.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrId,
    input  logic        idValid,
    input  logic [1:0]  readRs,
    input  logic [1:0]  readRt,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwdRsEx,
    output logic [1:0]  fwdRtEx,
    output logic        fwdRtMem,
    output logic [15:0] stallCount
);

    logic       id_wen;
    logic [4:0] id_dest;
    logic [1:0] id_ready;
    logic       stall_raw;

    ex_stage_t  ex_q, ex_d;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;

    instr_reg_write u_dec (
        .instr (instrId),
        .wen   (id_wen),
        .dest  (id_dest),
        .ready (id_ready)
    );

    function automatic logic [1:0] fwd_sel(input logic [1:0] rd_time, input logic [4:0] src,
                                           input mem_stage_t mem, input wb_stage_t wb);
        logic [1:0] sel;
        sel = FwdReg;
        if (rd_time != ReadNone) begin
            if (mem.v && mem.ready == ReadEx && mem.dest == src) begin
                sel = FwdExMem;
            end else if (wb.v && wb.dest == src) begin
                sel = FwdMemWb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        stall_raw = idValid && ex_q.v && ex_q.ready == ReadMem &&
                    ((readRs == ReadEx && rs_f(instrId) == ex_q.dest) ||
                     (readRt == ReadEx && rt_f(instrId) == ex_q.dest));
        // A flush squashes the consumer, so its stall must not take effect.
        stall    = stall_raw && !flush;
        fwdRsEx  = fwd_sel(ex_q.read_rs, ex_q.rs, mem_q, wb_q);
        fwdRtEx  = fwd_sel(ex_q.read_rt, ex_q.rt, mem_q, wb_q);
        fwdRtMem = mem_q.read_rt == ReadMem && wb_q.v && wb_q.dest == mem_q.rt;
    end

    always_comb begin
        ex_d = '0;
        if (idValid && !flush && !stall) begin
            ex_d.v       = id_wen;
            ex_d.dest    = id_dest;
            ex_d.ready   = id_ready;
            ex_d.rs      = rs_f(instrId);
            ex_d.rt      = rt_f(instrId);
            ex_d.read_rs = readRs;
            ex_d.read_rt = readRt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            stallCount <= 16'd0;
        end else begin
            ex_q          <= ex_d;
            mem_q.v       <= ex_q.v;
            mem_q.dest    <= ex_q.dest;
            mem_q.ready   <= ex_q.ready;
            mem_q.rt      <= ex_q.rt;
            mem_q.read_rt <= ex_q.read_rt;
            wb_q.v        <= mem_q.v;
            wb_q.dest     <= mem_q.dest;
            if (stall && stallCount != 16'hFFFF) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with an instruction-level pipeline model
// checked every cycle, plus literal expectations at key points.
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instrId;
    logic        idValid;
    logic [1:0]  readRs;
    logic [1:0]  readRt;
    logic        flush;
    logic        stall;
    logic [1:0]  fwdRsEx;
    logic [1:0]  fwdRtEx;
    logic        fwdRtMem;
    logic [15:0] stallCount;

    int checks = 0;
    int failures = 0;

    hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instrId    (instrId),
        .idValid    (idValid),
        .readRs     (readRs),
        .readRt     (readRt),
        .flush      (flush),
        .stall      (stall),
        .fwdRsEx    (fwdRsEx),
        .fwdRtEx    (fwdRtEx),
        .fwdRtMem   (fwdRtMem),
        .stallCount (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] AddR3  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] SubR4  = 32'h0065_2022; // sub  $4,$3,$5
    localparam logic [31:0] LwR3   = 32'h8C23_0000; // lw   $3,0($1)
    localparam logic [31:0] AddR33 = 32'h0063_2020; // add  $4,$3,$3
    localparam logic [31:0] SwR3   = 32'hAC23_0000; // sw   $3,0($1)
    localparam logic [31:0] AddiR0 = 32'h2020_0005; // addi $0,$1,5
    localparam logic [31:0] AddR00 = 32'h0000_2020; // add  $4,$0,$0
    localparam logic [31:0] AddR30 = 32'h0060_2020; // add  $4,$3,$0
    localparam logic [31:0] AddiR3 = 32'h2023_0007; // addi $3,$1,7

    // Model: each stage holds the whole instruction that occupies it.
    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic [1:0]  rrs;
        logic [1:0]  rrt;
    } slot_t;

    typedef struct packed {
        logic       w;
        logic [4:0] d;
        logic [1:0] r;
    } prod_t;

    slot_t ex_m, mem_m, wb_m;
    int    cnt_m;
    logic  started = 1'b0;

    function automatic prod_t m_dec(input logic [31:0] i);
        prod_t p;
        int    op;
        op = int'(i[31:26]);
        p = '0;
        if (op == 0 && i[5:0] != 6'h08) p = '{1'b1, i[15:11], 2'd1};
        else if (op == 'h23) p = '{1'b1, i[20:16], 2'd2};
        else if (op >= 'h08 && op <= 'h0F) p = '{1'b1, i[20:16], 2'd1};
        else if (op == 'h03) p = '{1'b1, 5'd31, 2'd1};
        if (p.d == 5'd0) p.w = 1'b0;
        return p;
    endfunction

    function automatic logic m_writes(input slot_t s, input logic [4:0] r);
        prod_t p;
        p = m_dec(s.ins);
        return s.v && p.w && p.d == r;
    endfunction

    function automatic logic m_stall();
        prod_t p;
        p = m_dec(ex_m.ins);
        if (!idValid || flush || !ex_m.v || !p.w || p.r != 2'd2) return 1'b0;
        return (readRs == 2'd1 && instrId[25:21] == p.d) ||
               (readRt == 2'd1 && instrId[20:16] == p.d);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [1:0] t, input logic [4:0] r);
        if (!ex_m.v || t == 2'd0) return 2'd0;
        if (m_writes(mem_m, r) && m_dec(mem_m.ins).r == 2'd1) return 2'd1;
        if (m_writes(wb_m, r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic m_fwd_mem();
        return mem_m.v && mem_m.rrt == 2'd2 && m_writes(wb_m, mem_m.ins[20:16]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ex_m    <= '0;
            mem_m   <= '0;
            wb_m    <= '0;
            cnt_m   <= 0;
            started <= 1'b1;
        end else begin
            wb_m  <= mem_m;
            mem_m <= ex_m;
            if (idValid && !flush && !m_stall()) ex_m <= '{1'b1, instrId, readRs, readRt};
            else ex_m <= '0;
            if (m_stall() && cnt_m < 65535) cnt_m <= cnt_m + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_stall", int'(stall), int'(m_stall()));
            chk("model_fwdRsEx", int'(fwdRsEx), int'(m_fwd(ex_m.rrs, ex_m.ins[25:21])));
            chk("model_fwdRtEx", int'(fwdRtEx), int'(m_fwd(ex_m.rrt, ex_m.ins[20:16])));
            chk("model_fwdRtMem", int'(fwdRtMem), int'(m_fwd_mem()));
            chk("model_stallCount", int'(stallCount), cnt_m);
        end
    end

    task automatic put(input logic [31:0] ins, input logic v, input logic [1:0] rs,
                       input logic [1:0] rt, input logic fl);
        instrId = ins;
        idValid = v;
        readRs  = rs;
        readRt  = rt;
        flush   = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) begin
            put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_fwdRsEx", int'(fwdRsEx), 0);
        chk("reset_fwdRtEx", int'(fwdRtEx), 0);
        chk("reset_fwdRtMem", int'(fwdRtMem), 0);
        chk("reset_count", int'(stallCount), 0);
        drain();

        // ALU -> dependent EX read
        put(AddR3, 1'b1, 2'd1, 2'd1, 1'b0); tick();
        put(SubR4, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("alu_nostall", int'(stall), 0);
        tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("alu_fwdRs", int'(fwdRsEx), 1);
        chk("alu_fwdRt", int'(fwdRtEx), 0);
        drain();

        // load-use: one stall, then forward from MEM/WB
        put(LwR3, 1'b1, 2'd1, 2'd0, 1'b0); tick();
        put(AddR33, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("lu_stall", int'(stall), 1);
        tick();
        put(AddR33, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("lu_stall_gone", int'(stall), 0);
        tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("lu_fwdRs", int'(fwdRsEx), 2);
        chk("lu_fwdRt", int'(fwdRtEx), 2);
        chk("lu_count", int'(stallCount), 1);
        drain();

        // load -> store data read at MEM
        put(LwR3, 1'b1, 2'd1, 2'd0, 1'b0); tick();
        put(SwR3, 1'b1, 2'd1, 2'd2, 1'b0);
        chk("sw_nostall", int'(stall), 0);
        tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("sw_fwdRtEx", int'(fwdRtEx), 0);
        tick();
        chk("sw_fwdRtMem", int'(fwdRtMem), 1);
        drain();

        // writes to $0 are never forwarded
        put(AddiR0, 1'b1, 2'd1, 2'd0, 1'b0); tick();
        put(AddR00, 1'b1, 2'd1, 2'd1, 1'b0); tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("r0_fwdRs", int'(fwdRsEx), 0);
        chk("r0_fwdRt", int'(fwdRtEx), 0);
        drain();

        // producer two ahead: forward from MEM/WB
        put(AddR3, 1'b1, 2'd1, 2'd1, 1'b0); tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0); tick();
        put(SubR4, 1'b1, 2'd1, 2'd1, 1'b0); tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("wb_fwdRs", int'(fwdRsEx), 2);
        drain();

        // two producers of $3: the younger one wins
        put(AddR3, 1'b1, 2'd1, 2'd1, 1'b0); tick();
        put(AddiR3, 1'b1, 2'd1, 2'd0, 1'b0); tick();
        put(SubR4, 1'b1, 2'd1, 2'd1, 1'b0); tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("young_fwdRs", int'(fwdRsEx), 1);
        drain();

        // flush beats a load-use stall
        put(LwR3, 1'b1, 2'd1, 2'd0, 1'b0); tick();
        put(AddR30, 1'b1, 2'd1, 2'd1, 1'b1);
        chk("flush_nostall", int'(stall), 0);
        tick();
        put(32'd0, 1'b0, 2'd0, 2'd0, 1'b0);
        chk("flush_fwdRs", int'(fwdRsEx), 0);
        chk("flush_count", int'(stallCount), 1);
        drain();

        // reset in the middle of a load-use stall
        put(LwR3, 1'b1, 2'd1, 2'd0, 1'b0); tick();
        put(AddR33, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("rst_pre_stall", int'(stall), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        put(AddR33, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_fwdRs", int'(fwdRsEx), 0);
        chk("rst_fwdRtMem", int'(fwdRtMem), 0);
        chk("rst_count", int'(stallCount), 0);
        drain();

        // an invalid ID slot enters EX as a bubble
        put(LwR3, 1'b0, 2'd1, 2'd0, 1'b0); tick();
        put(AddR33, 1'b1, 2'd1, 2'd1, 1'b0);
        chk("inval_nostall", int'(stall), 0);
        tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
